// File: rtl/ysyx_25040105_lsu_pkg.sv
// ysyx_25040105_lsu_pkg
//   Shared definitions for the load/store unit:
//   - RV32I funct3 codes for loads and stores
//   - 2-bit FSM state encoding
//   - helper that turns a byte offset into a bit shift amount
package ysyx_25040105_lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REQ      = 2'b01,
        ST_WAIT_RSP = 2'b10,
        ST_DONE     = 2'b11
    } lsu_state_e;

    // Byte offset within a word -> shift amount in bits.
    function automatic logic [4:0] lane_shift(input logic [1:0] byte_off);
        return {byte_off, 3'b000};
    endfunction

endpackage

// File: rtl/ysyx_25040105_lsu_align.sv
// ysyx_25040105_lsu_align
//   Combinational byte-lane logic for the LSU.
//   Ports:
//     funct3    in   3   memory op funct3
//     is_store  in   1   1 = store encoding, 0 = load encoding
//     addr_lo   in   2   address byte offset
//     wdata     in   32  store data (unshifted)
//     rdata     in   32  raw memory read word
//     wmask     out  4   byte enables for stores
//     wdata_sh  out  32  store data moved onto its byte lane
//     load_data out  32  extracted and extended load value
//     misalign  out  1   access misaligned or funct3 not legal for the op
module ysyx_25040105_lsu_align
    import ysyx_25040105_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [4:0]  shamt;
    logic [31:0] lane;

    assign shamt    = lane_shift(addr_lo);
    assign wdata_sh = wdata << shamt;
    assign lane     = rdata >> shamt;

    always_comb begin
        wmask     = 4'b0000;
        load_data = 32'd0;
        misalign  = 1'b0;
        if (is_store) begin
            case (funct3)
                SB: wmask = 4'b0001 << addr_lo;
                SH: begin
                    wmask    = 4'b0011 << addr_lo;
                    misalign = addr_lo[0];
                end
                SW: begin
                    wmask    = 4'b1111;
                    misalign = |addr_lo;
                end
                // Unknown store encodings are reported the same way as misalignment.
                default: misalign = 1'b1;
            endcase
        end else begin
            case (funct3)
                LB:  load_data = {{24{lane[7]}}, lane[7:0]};
                LH: begin
                    load_data = {{16{lane[15]}}, lane[15:0]};
                    misalign  = addr_lo[0];
                end
                LW: begin
                    load_data = lane;
                    misalign  = |addr_lo;
                end
                LBU: load_data = {24'd0, lane[7:0]};
                LHU: begin
                    load_data = {16'd0, lane[15:0]};
                    misalign  = addr_lo[0];
                end
                default: misalign = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_25040105_lsu.sv
// ysyx_25040105_lsu
//   Multi-cycle load/store unit between EXU and writeback. Accepts one op per
//   in_valid/in_ready handshake, issues at most one 32-bit memory request, and
//   presents the writeback result until out_ready.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     in_*                            EXU result (valid/ready handshake)
//     out_*                           writeback result (valid/ready handshake)
//     mem_req_*                       memory request channel (valid/ready)
//     mem_rsp_valid, mem_rsp_rdata    memory response, one beat per request
//   TIMEOUT_CYCLES: max wait per memory phase before reporting an error; 0 disables.
module ysyx_25040105_lsu
    import ysyx_25040105_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_wen,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic [31:0] out_wdata,
    output logic        out_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        is_load_q;
    logic        is_store_q;
    logic        reg_wen_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    logic [4:0]  out_rd_q;
    logic        out_wen_q;
    logic [31:0] out_wdata_q;
    logic        out_err_q;
    logic        mem_req_wen_q;
    logic [31:0] mem_req_addr_q;
    logic [31:0] mem_req_wdata_q;
    logic [3:0]  mem_req_wmask_q;

    // The aligner sees live inputs while idle (to decide misalignment and
    // build the request) and the latched op afterwards (to extend read data).
    logic        in_idle;
    logic [2:0]  al_funct3;
    logic        al_is_store;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata_sh;
    logic [31:0] al_load_data;
    logic        al_misalign;

    assign in_idle     = (state_q == ST_IDLE);
    assign al_funct3   = in_idle ? in_funct3   : funct3_q;
    assign al_is_store = in_idle ? in_is_store : is_store_q;
    assign al_addr_lo  = in_idle ? in_addr[1:0] : addr_lo_q;

    ysyx_25040105_lsu_align u_align (
        .funct3    (al_funct3),
        .is_store  (al_is_store),
        .addr_lo   (al_addr_lo),
        .wdata     (in_wdata),
        .rdata     (mem_rsp_rdata),
        .wmask     (al_wmask),
        .wdata_sh  (al_wdata_sh),
        .load_data (al_load_data),
        .misalign  (al_misalign)
    );

    // Timeout fires on the cycle that would be the TIMEOUT_CYCLES-th wait cycle.
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign cnt_d       = cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            funct3_q        <= 3'd0;
            addr_lo_q       <= 2'd0;
            is_load_q       <= 1'b0;
            is_store_q      <= 1'b0;
            reg_wen_q       <= 1'b0;
            cnt_q           <= 32'd0;
            out_rd_q        <= 5'd0;
            out_wen_q       <= 1'b0;
            out_wdata_q     <= 32'd0;
            out_err_q       <= 1'b0;
            mem_req_wen_q   <= 1'b0;
            mem_req_addr_q  <= 32'd0;
            mem_req_wdata_q <= 32'd0;
            mem_req_wmask_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        funct3_q   <= in_funct3;
                        addr_lo_q  <= in_addr[1:0];
                        is_load_q  <= in_is_load;
                        is_store_q <= in_is_store;
                        reg_wen_q  <= in_reg_wen;
                        out_rd_q   <= in_rd;
                        if (!(in_is_load || in_is_store)) begin
                            state_q     <= ST_DONE;
                            out_wdata_q <= in_wdata;
                            out_wen_q   <= in_reg_wen && (in_rd != 5'd0);
                            out_err_q   <= 1'b0;
                        end else if (al_misalign) begin
                            state_q     <= ST_DONE;
                            out_wdata_q <= 32'd0;
                            out_wen_q   <= 1'b0;
                            out_err_q   <= 1'b1;
                        end else begin
                            state_q         <= ST_REQ;
                            cnt_q           <= 32'd0;
                            mem_req_wen_q   <= in_is_store;
                            mem_req_addr_q  <= {in_addr[31:2], 2'b00};
                            mem_req_wdata_q <= in_is_store ? al_wdata_sh : 32'd0;
                            mem_req_wmask_q <= in_is_store ? al_wmask : 4'b0000;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state_q <= ST_WAIT_RSP;
                        cnt_q   <= 32'd0;
                    end else if (timeout_hit) begin
                        state_q     <= ST_DONE;
                        out_wdata_q <= 32'd0;
                        out_wen_q   <= 1'b0;
                        out_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        state_q   <= ST_DONE;
                        out_err_q <= 1'b0;
                        if (is_load_q) begin
                            out_wdata_q <= al_load_data;
                            out_wen_q   <= reg_wen_q && (out_rd_q != 5'd0);
                        end else begin
                            out_wdata_q <= 32'd0;
                            out_wen_q   <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_q     <= ST_DONE;
                        out_wdata_q <= 32'd0;
                        out_wen_q   <= 1'b0;
                        out_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = in_idle;
    assign out_valid     = (state_q == ST_DONE);
    assign out_rd        = out_rd_q;
    assign out_wen       = out_wen_q;
    assign out_wdata     = out_wdata_q;
    assign out_err       = out_err_q;
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_wen   = mem_req_wen_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign mem_req_wmask = mem_req_wmask_q;

endmodule
